// File: rtl/pwm_ramp_scheduler.sv
// pwm_ramp_scheduler: sole write master for the PWM register bank.
// Round-robin arbitration between SPI writes and a triangle duty-ramp engine.
module pwm_ramp_scheduler #(
  parameter int unsigned         ADDR_W    = 7,
  parameter int unsigned         DIV_W     = 16,
  parameter logic [ADDR_W-1:0]   DUTY_ADDR = 7'h04
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ramp_en,
  input  logic [7:0]        ramp_step,
  input  logic [DIV_W-1:0]  ramp_div,
  input  logic              spi_wr_valid,
  input  logic [ADDR_W-1:0] spi_wr_addr,
  input  logic [7:0]        spi_wr_data,
  output logic              spi_wr_ready,
  output logic              reg_wr_valid,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [7:0]        reg_wr_data,
  input  logic              reg_wr_ready,
  output logic [7:0]        duty_cur,
  output logic              ramp_dir
);

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_STEP,
    S_PEND
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DATA_W-1:0]   duty_q, duty_d;
  logic                dir_q, dir_d;
  logic                last_ramp_q, last_ramp_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic                loadable_c;
  logic                ramp_req_c;
  logic                spi_gnt_c;
  logic                ramp_gnt_c;
  logic                spi_duty_c;
  logic [DATA_W:0]     sum_c;
  logic [DATA_W:0]     diff_c;
  logic [DATA_W-1:0]   step_duty_c;
  logic                step_dir_c;

  // Arbitration: a tie goes to whichever side was not granted last
  assign loadable_c = !out_valid_q || reg_wr_ready;
  assign ramp_req_c = (state_q == S_PEND);
  assign spi_gnt_c  = loadable_c && spi_wr_valid && (!ramp_req_c || last_ramp_q);
  assign ramp_gnt_c = loadable_c && ramp_req_c && !spi_gnt_c;
  assign spi_duty_c = spi_gnt_c && (spi_wr_addr == DUTY_ADDR);

  // Triangle step with saturation at both ends and direction flip
  always_comb begin
    sum_c       = {1'b0, duty_q} + {1'b0, ramp_step};
    diff_c      = {1'b0, duty_q} - {1'b0, ramp_step};
    step_duty_c = duty_q;
    step_dir_c  = dir_q;
    if (!dir_q) begin
      if (sum_c >= (DATA_W+1)'(255)) begin
        step_duty_c = 8'hFF;
        step_dir_c  = 1'b1;
      end else begin
        step_duty_c = sum_c[DATA_W-1:0];
      end
    end else begin
      if (duty_q <= ramp_step) begin
        step_duty_c = '0;
        step_dir_c  = 1'b0;
      end else begin
        step_duty_c = diff_c[DATA_W-1:0];
      end
    end
  end

  // Output stage: holds addr/data while the bank stalls
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    last_ramp_d = last_ramp_q;
    if (loadable_c) begin
      out_valid_d = spi_gnt_c || ramp_gnt_c;
      if (spi_gnt_c) begin
        out_addr_d  = spi_wr_addr;
        out_data_d  = spi_wr_data;
        last_ramp_d = 1'b0;
      end else if (ramp_gnt_c) begin
        out_addr_d  = DUTY_ADDR;
        out_data_d  = duty_q;
        last_ramp_d = 1'b1;
      end
    end
  end

  // Ramp FSM next-state; an accepted SPI duty write overrides the engine
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: begin
        if (ramp_en) begin
          state_d = S_COUNT;
          div_d   = '0;
        end
      end
      S_COUNT: begin
        if (!ramp_en) begin
          state_d = S_IDLE;
        end else if (div_q == ramp_div) begin
          state_d = S_STEP;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_STEP: begin
        if (!ramp_en) begin
          state_d = S_IDLE;
        end else if (ramp_step == '0) begin
          state_d = S_COUNT;
        end else begin
          duty_d  = step_duty_c;
          dir_d   = step_dir_c;
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (ramp_gnt_c) begin
          state_d = ramp_en ? S_COUNT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (spi_duty_c) begin
      duty_d = spi_wr_data;
      dir_d  = dir_q;
      if (state_d == S_PEND) begin
        state_d = S_COUNT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      duty_q      <= '0;
      dir_q       <= 1'b0;
      last_ramp_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      last_ramp_q <= last_ramp_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  assign spi_wr_ready = spi_gnt_c;
  assign reg_wr_valid = out_valid_q;
  assign reg_wr_addr  = out_addr_q;
  assign reg_wr_data  = out_data_q;
  assign duty_cur     = duty_q;
  assign ramp_dir     = dir_q;

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Scoreboard bench for pwm_ramp_scheduler: directed stimulus pushes expected
// bank writes; a monitor pops and compares on every accepted write.
module tb_pwm_ramp_scheduler;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DIV_W  = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ramp_en = 1'b0;
  logic [7:0]        ramp_step = 8'd0;
  logic [DIV_W-1:0]  ramp_div = 16'd0;
  logic              spi_wr_valid = 1'b0;
  logic [ADDR_W-1:0] spi_wr_addr = 7'd0;
  logic [7:0]        spi_wr_data = 8'd0;
  logic              spi_wr_ready;
  logic              reg_wr_valid;
  logic [ADDR_W-1:0] reg_wr_addr;
  logic [7:0]        reg_wr_data;
  logic              reg_wr_ready = 1'b1;
  logic [7:0]        duty_cur;
  logic              ramp_dir;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  hs_cnt = 0;
  int  hs_last = 0;
  int  hs_prev = 0;

  pwm_ramp_scheduler #(.ADDR_W(ADDR_W), .DIV_W(DIV_W), .DUTY_ADDR(7'h04)) dut (
    .clk          (clk),
    .rst          (rst),
    .ramp_en      (ramp_en),
    .ramp_step    (ramp_step),
    .ramp_div     (ramp_div),
    .spi_wr_valid (spi_wr_valid),
    .spi_wr_addr  (spi_wr_addr),
    .spi_wr_data  (spi_wr_data),
    .spi_wr_ready (spi_wr_ready),
    .reg_wr_valid (reg_wr_valid),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_ready (reg_wr_ready),
    .duty_cur     (duty_cur),
    .ramp_dir     (ramp_dir)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    sb.push_back(w);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(2);
    sb.delete();
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_duty(input logic [7:0] target, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (duty_cur == target) break;
    end
    chk(name, 32'(duty_cur), 32'(target));
  endtask

  task automatic wait_empty(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      tick(1);
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every accepted bank write must match the head of the scoreboard
  initial begin : monitor
    wr_t exp_w;
    forever begin
      @(negedge clk);
      if (!rst && reg_wr_valid && reg_wr_ready) begin
        hs_prev = hs_last;
        hs_last = cyc;
        hs_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected",
                   reg_wr_addr, reg_wr_data);
        end else begin
          exp_w = sb.pop_front();
          chk("wr_addr", 32'(reg_wr_addr), 32'(exp_w.addr));
          chk("wr_data", 32'(reg_wr_data), 32'(exp_w.data));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int hs0;
    logic [7:0] tri_vals [9];
    tri_vals = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd191, 8'd127, 8'd63, 8'd0, 8'd64};

    // Reset state
    tick(3);
    chk("rst_valid",     32'(reg_wr_valid), 32'd0);
    chk("rst_addr",      32'(reg_wr_addr),  32'd0);
    chk("rst_data",      32'(reg_wr_data),  32'd0);
    chk("rst_duty",      32'(duty_cur),     32'd0);
    chk("rst_dir",       32'(ramp_dir),     32'd0);
    chk("rst_spi_ready", 32'(spi_wr_ready), 32'd0);
    rst = 1'b0;
    tick(2);
    chk("idle_valid", 32'(reg_wr_valid), 32'd0);

    // Triangle sweep, div=3 step=64
    ramp_div  = 16'd3;
    ramp_step = 8'd64;
    foreach (tri_vals[i]) push(7'h04, tri_vals[i]);
    ramp_en = 1'b1;
    wait_empty(120, "t1_drain");
    ramp_en = 1'b0;
    chk("t1_write_period", 32'(hs_last - hs_prev), 32'd6);
    tick(10);
    chk("t1_duty_kept", 32'(duty_cur), 32'd64);
    chk("t1_dir_kept",  32'(ramp_dir), 32'd0);

    // Ties: SPI wins first after reset, then ramp wins the next tie
    pulse_reset();
    ramp_div  = 16'd20;
    ramp_step = 8'd8;
    ramp_en   = 1'b1;
    wait_duty(8'd8, 60, "t2_pend");
    ramp_en = 1'b0;
    push(7'h00, 8'hFF);
    push(7'h04, 8'h08);
    push(7'h01, 8'hAA);
    spi_wr_valid = 1'b1;
    spi_wr_addr  = 7'h00;
    spi_wr_data  = 8'hFF;
    #1;
    chk("t2_tie1_spi_ready", 32'(spi_wr_ready), 32'd1);
    tick(1);
    spi_wr_addr  = 7'h01;
    spi_wr_data  = 8'hAA;
    reg_wr_ready = 1'b0;
    #1;
    chk("t3_stall_spi_ready", 32'(spi_wr_ready), 32'd0);
    tick(10);
    chk("t3_hold_valid", 32'(reg_wr_valid), 32'd1);
    chk("t3_hold_addr",  32'(reg_wr_addr),  32'h00);
    chk("t3_hold_data",  32'(reg_wr_data),  32'hFF);
    chk("t3_hold_duty",  32'(duty_cur),     32'h08);
    chk("t3_stall_spi_ready_late", 32'(spi_wr_ready), 32'd0);
    reg_wr_ready = 1'b1;
    #1;
    chk("t2_tie2_ramp_wins", 32'(spi_wr_ready), 32'd0);
    tick(1);
    #1;
    chk("t2_spi_alone_ready", 32'(spi_wr_ready), 32'd1);
    tick(1);
    spi_wr_valid = 1'b0;
    wait_empty(20, "t2_drain");

    // SPI duty write drops a pending ramp write
    pulse_reset();
    ramp_div  = 16'd0;
    ramp_step = 8'd16;
    push(7'h04, 8'h10);
    push(7'h04, 8'h20);
    push(7'h04, 8'h30);
    push(7'h04, 8'h40);
    push(7'h04, 8'h80);
    push(7'h04, 8'h90);
    ramp_en = 1'b1;
    wait_duty(8'h50, 60, "t4_pend");
    spi_wr_valid = 1'b1;
    spi_wr_addr  = 7'h04;
    spi_wr_data  = 8'h80;
    #1;
    chk("t4_spi_ready", 32'(spi_wr_ready), 32'd1);
    tick(1);
    spi_wr_valid = 1'b0;
    chk("t4_duty_override", 32'(duty_cur), 32'h80);
    chk("t4_dir_up",        32'(ramp_dir), 32'd0);
    wait_duty(8'h90, 20, "t4_next_step");
    ramp_en = 1'b0;
    wait_empty(20, "t4_drain");

    // Reset mid-handshake
    reg_wr_ready = 1'b0;
    spi_wr_valid = 1'b1;
    spi_wr_addr  = 7'h10;
    spi_wr_data  = 8'h55;
    tick(1);
    spi_wr_valid = 1'b0;
    tick(3);
    chk("t5_stalled_valid", 32'(reg_wr_valid), 32'd1);
    chk("t5_stalled_addr",  32'(reg_wr_addr),  32'h10);
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(reg_wr_valid), 32'd0);
    chk("t5_async_addr",  32'(reg_wr_addr),  32'd0);
    chk("t5_async_data",  32'(reg_wr_data),  32'd0);
    chk("t5_async_duty",  32'(duty_cur),     32'd0);
    chk("t5_async_dir",   32'(ramp_dir),     32'd0);
    tick(2);
    sb.delete();
    rst = 1'b0;
    reg_wr_ready = 1'b1;
    tick(20);
    chk("t5_idle_valid", 32'(reg_wr_valid), 32'd0);
    chk("t5_idle_duty",  32'(duty_cur),     32'd0);
    ramp_div  = 16'd2;
    ramp_step = 8'd5;
    push(7'h04, 8'h05);
    ramp_en = 1'b1;
    wait_duty(8'h05, 40, "t5_first_step");
    ramp_en = 1'b0;
    wait_empty(20, "t5_drain");

    // step=0 issues nothing; then div=0 step=1 back-to-back writes
    ramp_step = 8'd0;
    ramp_div  = 16'd0;
    hs0 = hs_cnt;
    ramp_en = 1'b1;
    tick(100);
    chk("t6_no_writes", 32'(hs_cnt - hs0), 32'd0);
    chk("t6_duty_same", 32'(duty_cur),     32'h05);
    ramp_en = 1'b0;
    pulse_reset();
    ramp_step = 8'd1;
    for (int v = 1; v <= 8; v++) push(7'h04, 8'(v));
    ramp_en = 1'b1;
    wait_duty(8'd8, 60, "t6_count_up");
    ramp_en = 1'b0;
    wait_empty(20, "t6_drain");
    chk("t6_write_period", 32'(hs_last - hs_prev), 32'd3);
    tick(10);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
